// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the FSM state encoding, default geometry and the word type.
package imem_loader_pkg;

    localparam int TAM_ENTRADA    = 1024;
    localparam int TAM_SALIDA     = 32;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = TAM_SALIDA / 8;

    typedef logic [TAM_SALIDA-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        CHECK,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// master: loader side (takes bytes, drives we/waddr/wdata); slave: environment.
interface imem_loader_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, we, waddr, wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into a memory word, lane by lane.
// Ports: clk/rst, clear, shift_en, byte_in -> word, last_byte.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int tam_salida = TAM_SALIDA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    output logic [tam_salida-1:0] word,
    output logic                  last_byte
);

    localparam int BPW = tam_salida / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IW-1:0]         idx_q, idx_d;
    logic [tam_salida-1:0] word_q, word_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (shift_en) begin
            for (int i = 0; i < BPW; i++) begin
                if (idx_q == IW'(i)) word_d[i*8 +: 8] = byte_in;
            end
            idx_d = idx_q + IW'(1);
        end
    end

    assign word      = word_q;
    assign last_byte = (idx_q == IW'(BPW - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a counted LE program image into instruction memory, holding the core.
// Ports: CLK, RST, start, bus (bytes in / mem write out), busy, done, error, cpu_hold.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int tam_entrada = TAM_ENTRADA,
    parameter int tam_salida  = TAM_SALIDA
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);

    localparam int AW = $clog2(tam_entrada);
    localparam int CW = AW + 1;

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [tam_salida-1:0] wdata_q, wdata_d;

    logic                  accept;
    logic                  asm_clear;
    logic                  asm_shift;
    logic                  asm_last;
    logic [tam_salida-1:0] asm_word;
    logic                  last_word;
    logic                  too_big;

    assign accept    = bus.byte_valid & bus.byte_ready;
    assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, count_q};
    assign too_big   = {1'b0, count_q} > 17'(tam_entrada);

    imem_loader_word_assembler #(
        .tam_salida(tam_salida)
    ) u_asm (
        .clk      (CLK),
        .rst      (RST),
        .clear    (asm_clear),
        .shift_en (asm_shift),
        .byte_in  (bus.byte_data),
        .word     (asm_word),
        .last_byte(asm_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d    = HDR_LO;
                    count_d    = '0;
                    word_cnt_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    count_d[7:0] = bus.byte_data;
                    state_d      = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    count_d[15:8] = bus.byte_data;
                    state_d       = CHECK;
                end
            end
            CHECK: begin
                if (count_q == '0)  state_d = DONE;
                else if (too_big)   state_d = ERROR;
                else                state_d = DATA;
            end
            DATA: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_last) state_d = WRITE;
                end
            end
            WRITE: begin
                // Capture the strobe values so the port holds them afterwards
                waddr_d = word_cnt_q[AW-1:0];
                wdata_d = asm_word;
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_cnt_d = word_cnt_q + CW'(1);
                    asm_clear  = 1'b1;
                    state_d    = DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = 1'b0;
        bus.we         = 1'b0;
        bus.waddr      = waddr_q;
        bus.wdata      = wdata_q;
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        cpu_hold       = 1'b1;
        unique case (state_q)
            HDR_LO, HDR_HI, DATA: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
            CHECK: busy = 1'b1;
            WRITE: begin
                busy      = 1'b1;
                bus.we    = 1'b1;
                bus.waddr = word_cnt_q[AW-1:0];
                bus.wdata = asm_word;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image loads, header edge cases, gaps, reset abort.
// Writes are captured into a bench memory model and compared with the source image.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic busy, done, error, cpu_hold;

    imem_loader_if #(.AW(10), .DW(32)) bus ();

    imem_loader #(
        .tam_entrada(1024),
        .tam_salida (32)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .cpu_hold(cpu_hold)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_we_cyc = 0;
    int wr_n = 0;
    int start_at_word = -1;

    logic [31:0] img [0:1023];
    logic [31:0] mem [0:1023];
    logic [9:0]  q_addr [$];
    logic [31:0] q_data [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Write monitor: models the instruction memory and checks write latency
    always @(negedge CLK) begin
        if (bus.we === 1'b1) begin
            mem[bus.waddr] = bus.wdata;
            q_addr.push_back(bus.waddr);
            q_data.push_back(bus.wdata);
            wr_n++;
            last_we_cyc = cyc;
            check("we_lat", 32'(cyc), 32'(acc_cyc + 1));
        end
    end

    task automatic clr();
        wr_n = 0;
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        repeat (gap) begin @(posedge CLK); #1; end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.byte_ready) begin
                acc_cyc = cyc;
                ok = 1;
            end
            @(posedge CLK); #1;
            if (ok) break;
        end
        bus.byte_valid = 1'b0;
        if (!ok) check("byte_tmo", 32'd0, 32'd1);
    endtask

    function automatic int gap_of(input int maxgap);
        return (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    endfunction

    task automatic send_load(input int hdr, input int nw, input int maxgap);
        logic [31:0] w;
        logic [15:0] h;
        h = hdr[15:0];
        send_byte(h[7:0], gap_of(maxgap));
        send_byte(h[15:8], gap_of(maxgap));
        for (int k = 0; k < nw; k++) begin
            w = img[k];
            for (int b = 0; b < 4; b++) begin
                if (k == start_at_word && b == 0) start = 1'b1;
                send_byte(w[8*b +: 8], gap_of(maxgap));
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_end(output int c);
        bit ok = 0;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (done || error) begin
                ok = 1;
                c = cyc;
                break;
            end
        end
        if (!ok) check("end_tmo", 32'd0, 32'd1);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_n"}, 32'(wr_n), 32'(n));
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            check({tag, "_a"}, 32'(q_addr[i]), 32'(i));
            check({tag, "_d"}, q_data[i], img[i]);
        end
    endtask

    int c_end;
    int nmis;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_rdy", 32'(bus.byte_ready), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_waddr", 32'(bus.waddr), 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {30'd0, done, error}, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Three words, no gaps
        img[0] = 32'h0000_0013;
        img[1] = 32'hDEAD_BEEF;
        img[2] = 32'h1234_5678;
        clr();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rdy", 32'(bus.byte_ready), 32'd1);
        send_load(3, 3, 0);
        wait_end(c_end);
        check_writes("t1", 3);
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_done_lat", 32'(c_end), 32'(last_we_cyc + 1));
        check("t1_hold_a", 32'(bus.waddr), 32'd2);
        check("t1_hold_d", bus.wdata, 32'h1234_5678);
        check("t1_we_off", 32'(bus.we), 32'd0);

        // Zero-length image
        clr();
        pulse_start();
        check("t2_clr_done", 32'(done), 32'd0);
        check("t2_hold_on", 32'(cpu_hold), 32'd1);
        send_load(0, 0, 0);
        wait_end(c_end);
        check("t2_n", 32'(wr_n), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd0);

        // Oversized header 1025, then recovery
        clr();
        pulse_start();
        send_load(1025, 0, 0);
        wait_end(c_end);
        check("t3_err", 32'(error), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_rdy", 32'(bus.byte_ready), 32'd0);
        check("t3_n", 32'(wr_n), 32'd0);
        img[0] = 32'hA5C3_0F96;
        pulse_start();
        check("t3_err_clr", 32'(error), 32'd0);
        send_load(1, 1, 0);
        wait_end(c_end);
        check_writes("t3r", 1);
        check("t3r_done", 32'(done), 32'd1);
        check("t3r_err", 32'(error), 32'd0);

        // Two words with random valid gaps
        img[0] = 32'hCAFE_F00D;
        img[1] = 32'h0102_0304;
        clr();
        pulse_start();
        send_load(2, 2, 5);
        wait_end(c_end);
        check_writes("t4", 2);
        check("t4_done", 32'(done), 32'd1);

        // Reset after two bytes of word 1
        img[0] = 32'h1111_2222;
        img[1] = 32'h3333_4444;
        img[2] = 32'h5555_6666;
        clr();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 0);
        send_byte(8'h44, 0);
        send_byte(8'h44, 0);
        RST = 1'b1;
        #1;
        check("t5_we", 32'(bus.we), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rdy", 32'(bus.byte_ready), 32'd0);
        check("t5_hold", 32'(cpu_hold), 32'd1);
        check("t5_waddr", 32'(bus.waddr), 32'd0);
        check("t5_wdata", bus.wdata, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("t5_n", 32'(wr_n), 32'd1);
        clr();
        pulse_start();
        send_load(3, 3, 0);
        wait_end(c_end);
        check_writes("t5r", 3);
        check("t5r_done", 32'(done), 32'd1);

        // Full-depth image with a start pulse during the load
        for (int i = 0; i < 1024; i++) begin
            img[i] = 32'(i) * 32'h9E37_79B9 + 32'h0000_0013;
            mem[i] = 32'hBAD0_0000;
        end
        clr();
        start_at_word = 7;
        pulse_start();
        send_load(1024, 1024, 0);
        start_at_word = -1;
        wait_end(c_end);
        check("t6_n", 32'(wr_n), 32'd1024);
        check("t6_last_a", 32'(q_addr[q_addr.size()-1]), 32'd1023);
        check("t6_done", 32'(done), 32'd1);
        check("t6_err", 32'(error), 32'd0);
        nmis = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== img[i]) nmis++;
        end
        check("t6_rom_rd", 32'(nmis), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer-side companion to the instruction ROM read path. It accepts a byte stream carrying a program image and writes it word by word into the instruction memory's write port. The stream is a 16-bit little-endian word count followed by the words, each sent as 4 bytes, least significant byte first. While loading, the block holds the core in reset and releases it only after a complete, valid image has been written.

Parameters:
tam_entrada, 1024, instruction memory depth in words (power of 2)
tam_salida, 32, memory word width in bits (multiple of 8)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse that begins a load
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  8  incoming stream byte
byte_ready  out  1  loader accepts a byte this cycle
we  out  1  memory write strobe, one cycle per word
waddr  out  $clog2(tam_entrada)  memory word address
wdata  out  tam_salida  assembled word
busy  out  1  load in progress
done  out  1  image fully written (sticky)
error  out  1  header count exceeds depth (sticky)
cpu_hold  out  1  keeps the core in reset

Behaviour:
- Reset is asynchronous and active-high on RST; the block has one clock, CLK. Reset values: byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, cpu_hold=1. FSM goes to IDLE. Byte index, word counter and count register go to 0.
- Byte transfer: a byte is accepted only on a cycle with byte_valid && byte_ready. byte_ready is 1 only in HDR_LO, HDR_HI and DATA; it is combinational from state.
- FSM states: IDLE, HDR_LO, HDR_HI, CHECK, DATA, WRITE, DONE, ERROR.
- IDLE, DONE, ERROR: on start go to HDR_LO, clear done/error, zero counters, and set cpu_hold=1. start is ignored in every other state.
- HDR_LO: on accept, count[7:0] = byte, then go to HDR_HI.
- HDR_HI: on accept, count[15:8] = byte, then go to CHECK.
- CHECK (one cycle):
  - count==0 goes to DONE with no writes.
  - count > tam_entrada, compared at 17 bits, goes to ERROR.
  - Otherwise go to DATA.
- DATA: on each accept, shift the byte into lane byte_idx (little-endian). After the byte with byte_idx = tam_salida/8-1 is accepted, go to WRITE.
- WRITE (one cycle): we=1, waddr = word_cnt[$clog2(tam_entrada)-1:0], wdata = assembled word.
  - If word_cnt == count-1, go to DONE.
  - Otherwise word_cnt++, byte_idx = 0, and go to DATA.
- Latency: we is asserted exactly 1 cycle after the final byte of a word is accepted. At most one byte is accepted per cycle.
- The word counter is $clog2(tam_entrada)+1 bits wide. With count == tam_entrada, the last write goes to address tam_entrada-1 and the address never wraps.
- busy=1 in HDR_LO..WRITE. done=1 only in DONE. error=1 only in ERROR.
- cpu_hold=0 only in DONE. It stays 1 in IDLE after reset, during a load, and in ERROR.
- waddr and wdata hold their last values when we=0. Outside WRITE, we=0.
- Reset asserted mid-load aborts immediately; no partial-word write is issued.
- byte_valid gaps of any length in DATA or HDR_* simply stall the load, with no timeout. Bytes presented while byte_ready=0 are not consumed.

Decomposition:
- Package imem_loader_pkg holds:
  - enum state_t with the 8 states
  - HDR_BYTES=2
  - BYTES_PER_WORD = tam_salida/8
  - typedef word_t = logic [tam_salida-1:0]
- Sub-module word_assembler (byte shift register plus byte_idx counter, with clear and last_byte outputs) keeps the FSM free of lane logic.

Test Plan:
- Start, then header 03 00, then words 0x00000013, 0xDEADBEEF, 0x12345678 sent LE with no gaps -> exactly three we pulses at waddr 0/1/2 with those wdata; done=1 and cpu_hold=0 one cycle after the third WRITE.
- Header 00 00 -> CHECK then DONE; zero we pulses; done=1, cpu_hold=0.
- Header 01 04 (count 1025) -> error=1, done=0, cpu_hold=1, no we pulses; a following start plus valid image of count 1 recovers with done=1.
- Count 2 with random byte_valid gaps of 0-5 cycles -> same writes as the gap-free case; each we arrives 1 cycle after the 4th byte of its word is accepted.
- RST pulsed after 2 bytes of word 1 in a 3-word load -> outputs at reset values immediately, no we pulse for word 1; a reload then completes correctly.
- Count 1024 filled from a 1024-word program image -> last we at waddr 1023; a bench memory model matches the image word-for-word when read back through the ROM read port. A start pulse during busy has no effect.
